// File: rtl/bcd_encode_module_if.sv
// Handshake and data bundle between a binary-score producer and the BCD encoder.
interface bcd_encode_module_if;
    logic [19:0] Bin_Data;
    logic        Start_Sig;
    logic        Busy;
    logic        Done_Sig;
    logic        Ovf_Flag;
    logic [23:0] Number_Sig;

    modport master (
        output Bin_Data,
        output Start_Sig,
        input  Busy,
        input  Done_Sig,
        input  Ovf_Flag,
        input  Number_Sig
    );

    modport slave (
        input  Bin_Data,
        input  Start_Sig,
        output Busy,
        output Done_Sig,
        output Ovf_Flag,
        output Number_Sig
    );
endinterface

// File: rtl/bcd_encode_module.sv
// Sequential 20-bit binary to 6-digit BCD encoder (double dabble, one bit per cycle).
// Define SMG_LZ_BLANK_EN to replace leading zero digits with the blank code 4'hF.
module bcd_encode_module (
    input  logic              clk,
    input  logic              rst_n,
    bcd_encode_module_if.slave io_bus
);

    localparam int unsigned BIN_W  = 20;
    localparam int unsigned DIGITS = 6;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned CAT_W  = BCD_W + BIN_W;

    localparam logic [BIN_W-1:0] BIN_MAX   = BIN_W'(999999);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   r_number;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic               w_start;
    logic               w_last;
    logic               w_ovf_in;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [CAT_W-1:0]   w_cat;
    logic [CAT_W-1:0]   w_shift;
    logic [BCD_W-1:0]   w_bcd_res;
    logic [BCD_W-1:0]   w_number_nxt;

    assign w_start  = (r_state == IDLE) && io_bus.Start_Sig;
    assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_ITER);
    assign w_ovf_in = (io_bus.Bin_Data > BIN_MAX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; Start_Sig is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (io_bus.Start_Sig) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)           w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would overflow past 9 after doubling
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign w_cat     = {w_bcd_adj, r_bin};
    assign w_shift   = w_cat << 1;
    assign w_bcd_res = w_shift[BIN_W +: BCD_W];

`ifdef SMG_LZ_BLANK_EN
    logic w_lead;

    // Blank leading zeros from the top digit down; the units digit always shows
    always_comb begin
        w_number_nxt = w_bcd_res;
        w_lead       = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (w_lead && (w_bcd_res[i*4 +: 4] == 4'd0)) begin
                w_number_nxt[i*4 +: 4] = 4'hF;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    assign w_number_nxt = w_bcd_res;
`endif

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_number <= '0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == SHIFT);
            r_done <= (w_state_nxt == DONE);
            if (w_start) begin
                r_bin <= w_ovf_in ? BIN_MAX : io_bus.Bin_Data;
                r_bcd <= '0;
                r_cnt <= '0;
                r_ovf <= w_ovf_in;
            end else if (r_state == SHIFT) begin
                r_bcd <= w_shift[BIN_W +: BCD_W];
                r_bin <= w_shift[BIN_W-1:0];
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_number <= w_number_nxt;
                end
            end
        end
    end

    assign io_bus.Busy       = r_busy;
    assign io_bus.Done_Sig   = r_done;
    assign io_bus.Ovf_Flag   = r_ovf;
    assign io_bus.Number_Sig = r_number;

endmodule

// File: tb/tb_bcd_encode_module.sv
// Directed scoreboard bench for bcd_encode_module (honours SMG_LZ_BLANK_EN when defined).
module tb_bcd_encode_module;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    bcd_encode_module_if bus ();

    bcd_encode_module dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    typedef struct packed {
        logic [23:0] num;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Decimal reference: digits by division, optional leading-zero blanking
    function automatic logic [23:0] model(input int unsigned v);
        int unsigned s;
        logic [23:0] r;
`ifdef SMG_LZ_BLANK_EN
        bit lead;
`endif
        s = (v > 999999) ? 999999 : v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(s % 10);
            s = s / 10;
        end
`ifdef SMG_LZ_BLANK_EN
        lead = 1'b1;
        for (int i = 5; i > 0; i--) begin
            if (lead && (r[i*4 +: 4] == 4'd0)) r[i*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return r;
    endfunction

    task automatic push_exp(input int unsigned v);
        exp_t e;
        e.num = model(v);
        e.ovf = (v > 999999);
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed unexpected Done_Sig expected none", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_num"}, 32'(bus.Number_Sig), 32'(e.num));
            chk({tag, "_ovf"}, 32'(bus.Ovf_Flag), 32'(e.ovf));
        end
    endtask

    task automatic idle_quiet(input int n, input string tag);
        int dones = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.Done_Sig) dones++;
        end
        chk({tag, "_no_done"}, 32'(dones), 32'd0);
    endtask

    // One conversion; optional extra start pulse at cycle inj_cycle that must be ignored
    task automatic run_conv(input int unsigned data, input int inj_cycle,
                            input int unsigned inj_data, input string tag);
        logic [23:0] prev;
        int busy_cnt = 0;
        int lat      = 0;
        bit seen     = 1'b0;
        bit hold_ok  = 1'b1;
        @(negedge clk);
        prev           = bus.Number_Sig;
        bus.Bin_Data   = 20'(data);
        bus.Start_Sig  = 1'b1;
        push_exp(data);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus.Start_Sig = 1'b0;
            if (k == 3) bus.Bin_Data = 20'($urandom);
            if (k == 1) chk({tag, "_ovf_e0"}, 32'(bus.Ovf_Flag), 32'(data > 999999));
            if (bus.Busy) begin
                busy_cnt++;
                if (bus.Number_Sig !== prev) hold_ok = 1'b0;
            end
            if (inj_cycle != 0 && k == inj_cycle) begin
                bus.Bin_Data  = 20'(inj_data);
                bus.Start_Sig = 1'b1;
            end
            if (bus.Done_Sig) begin
                seen = 1'b1;
                lat  = k;
                pop_check(tag);
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'd21);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd20);
        chk({tag, "_number_hold"}, 32'(hold_ok), 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.Done_Sig), 32'd0);
        chk({tag, "_busy_after"}, 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done_k[$];
        logic [23:0] pre_num;

        bus.Bin_Data  = '0;
        bus.Start_Sig = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("reset_busy", 32'(bus.Busy), 32'd0);
        chk("reset_done", 32'(bus.Done_Sig), 32'd0);
        chk("reset_ovf", 32'(bus.Ovf_Flag), 32'd0);
        chk("reset_num", 32'(bus.Number_Sig), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_conv(123456, 0, 0, "c123456");
        run_conv(0, 0, 0, "c0");
        run_conv(507, 0, 0, "c507");
        run_conv(1000000, 0, 0, "covf");
        run_conv(42, 0, 0, "c42");
        run_conv(77, 5, 555, "cinject");
        idle_quiet(25, "cinject_after");

        // Abort an overflowing conversion with reset at cycle 10
        pre_num = bus.Number_Sig;
        chk("pre_reset_num_nonzero", 32'(pre_num != 24'd0), 32'd1);
        @(negedge clk);
        bus.Bin_Data  = 20'hFFFFF;
        bus.Start_Sig = 1'b1;
        @(negedge clk);
        bus.Start_Sig = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_mid", 32'(bus.Busy), 32'd1);
        chk("abort_ovf_mid", 32'(bus.Ovf_Flag), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.Busy), 32'd0);
        chk("abort_done", 32'(bus.Done_Sig), 32'd0);
        chk("abort_ovf", 32'(bus.Ovf_Flag), 32'd0);
        chk("abort_num", 32'(bus.Number_Sig), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_quiet(30, "abort_after");
        run_conv(999999, 0, 0, "c999999");

        // Start held high: back-to-back conversions every 22 cycles
        @(negedge clk);
        bus.Bin_Data  = 20'd1;
        bus.Start_Sig = 1'b1;
        repeat (4) push_exp(1);
        for (int k = 1; k <= 88; k++) begin
            @(negedge clk);
            if (bus.Done_Sig) begin
                done_k.push_back(k);
                pop_check("held");
            end
            if (k == 87) bus.Start_Sig = 1'b0;
        end
        chk("held_done_count", 32'(done_k.size()), 32'd4);
        if (done_k.size() == 4) begin
            chk("held_first", 32'(done_k[0]), 32'd21);
            for (int i = 1; i < 4; i++) chk("held_period", 32'(done_k[i] - done_k[i-1]), 32'd22);
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);
        idle_quiet(25, "held_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_encode_module.md
BCD_ENCODE_MODULE -- requirements
Module: bcd_encode_module

Interface
REQ-001 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port Bin_Data  input  20  unsigned binary value to encode (score/time).
REQ-004 SHALL have port Start_Sig  input  1  conversion request, sampled on rising clk.
REQ-005 SHALL have port Busy  output  1  high while conversion in progress.
REQ-006 SHALL have port Done_Sig  output  1  one-cycle pulse when Number_Sig is updated.
REQ-007 SHALL have port Ovf_Flag  output  1  last accepted Bin_Data exceeded 999999.
REQ-008 SHALL have port Number_Sig  output  24  six BCD digits for the display mux; [23:20] is the most significant digit, [3:0] the least.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-010 In IDLE with Start_Sig=1 at edge E0, SHALL capture Bin_Data, saturated to 999999 if greater, and SHALL enter SHIFT.
REQ-011 At E0, SHALL set Ovf_Flag to 1 if Bin_Data > 999999, else 0; it holds until the next accepted start.
REQ-012 SHIFT SHALL run exactly 20 iterations, one per edge E1..E20, using a 5-bit iteration counter.
REQ-013 Each iteration SHALL add 3 to every BCD nibble >= 5, then shift the {BCD, binary} register left by one bit (double dabble).
REQ-014 At E20, SHALL load Number_Sig atomically from the BCD register and enter DONE.
REQ-015 Done_Sig SHALL be high only in DONE (the cycle after E20); DONE SHALL return to IDLE at the next edge.
REQ-016 Busy SHALL be high exactly while the state is SHIFT.
REQ-017 Number_Sig SHALL hold its previous value throughout SHIFT; there are no intermediate values.
REQ-018 Start_Sig SHALL be ignored in SHIFT and in DONE; no queuing.
REQ-019 Start_Sig held high continuously SHALL restart a conversion at each return to IDLE, giving a 22-cycle period.
REQ-020 Bin_Data changes after E0 SHALL NOT affect the conversion in progress.
REQ-021 Conversion latency SHALL be fixed at 21 cycles from E0 to the Done_Sig rising edge.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, counter=0, Busy=0, Done_Sig=0, Ovf_Flag=0, Number_Sig=24'h000000, and clear internal shift registers, independent of clk.
REQ-023 Reset asserted mid-conversion SHALL abort it with no Done_Sig pulse; the first Start_Sig after release SHALL begin a fresh conversion.
REQ-024 Deassertion SHALL take effect at the first rising clk edge after rst_n goes high.

Configuration
REQ-025 Macro SMG_LZ_BLANK_EN defined: at E20, each leading zero digit from [23:20] downward SHALL be replaced by 4'hF (blank code); digit [3:0] is never blanked (value 0 -> 24'hFFFFF0).
REQ-026 Macro SMG_LZ_BLANK_EN undefined: Number_Sig SHALL be plain BCD with zero digits shown (value 0 -> 24'h000000); the blanking logic SHALL be absent.
REQ-027 Blanking SHALL NOT change latency, handshake, or Ovf_Flag.

Verification
REQ-028 Bin_Data=123456, Start pulse at E0 -> Busy high for 20 cycles; Done_Sig high for one cycle 21 cycles after E0; Number_Sig=24'h123456; Ovf_Flag=0.
REQ-029 Bin_Data=0 -> Number_Sig=24'h000000 (macro off) / 24'hFFFFF0 (macro on); Bin_Data=507 with macro on -> 24'hFFF507.
REQ-030 Bin_Data=1000000 -> Number_Sig=24'h999999, Ovf_Flag=1; a following Bin_Data=42 -> 24'h000042, Ovf_Flag=0.
REQ-031 Start pulse at E0+5 during SHIFT with a different Bin_Data -> ignored; a single Done_Sig with the original value.
REQ-032 rst_n low at E0+10 -> all outputs at reset values immediately, no Done_Sig; start after release with Bin_Data=999999 -> 24'h999999.
REQ-033 Start_Sig held high continuously with Bin_Data=1 -> Done_Sig pulses every 22 cycles; Number_Sig=24'h000001 (macro off).
